// File: rtl/id_stage_if.sv
// id_stage_if
//   Groups the decode-stage signals exchanged between the instruction-decode
//   stage (master) and id_stage_core (slave).
//   Register-file traffic: readRegister1/2, writeRegister, writeData and
//   regWrite go in; readData1/2 come out.
//   Control decode: opCode goes in; writeBackControl, memAccessControl and
//   calculationControl come out.
//   Hazard detection: idExMemRead, idExRt, ifIdRs and ifIdRt go in;
//   pcWrite, ifIdWrite and bubbleInstruction come out.
interface id_stage_if;
    logic [4:0]  readRegister1;
    logic [4:0]  readRegister2;
    logic [4:0]  writeRegister;
    logic [31:0] writeData;
    logic        regWrite;
    logic [5:0]  opCode;
    logic        idExMemRead;
    logic [4:0]  idExRt;
    logic [4:0]  ifIdRs;
    logic [4:0]  ifIdRt;
    logic [31:0] readData1;
    logic [31:0] readData2;
    logic [1:0]  writeBackControl;
    logic [1:0]  memAccessControl;
    logic [3:0]  calculationControl;
    logic        pcWrite;
    logic        ifIdWrite;
    logic        bubbleInstruction;

    modport master (
        output readRegister1, readRegister2, writeRegister, writeData, regWrite,
        output opCode, idExMemRead, idExRt, ifIdRs, ifIdRt,
        input  readData1, readData2, writeBackControl, memAccessControl,
        input  calculationControl, pcWrite, ifIdWrite, bubbleInstruction
    );

    modport slave (
        input  readRegister1, readRegister2, writeRegister, writeData, regWrite,
        input  opCode, idExMemRead, idExRt, ifIdRs, ifIdRt,
        output readData1, readData2, writeBackControl, memAccessControl,
        output calculationControl, pcWrite, ifIdWrite, bubbleInstruction
    );
endinterface

// File: rtl/id_stage_core.sv
// id_stage_core
//   Decode-stage support core: 32x32 register file (two combinational read
//   ports, one rising-edge write port), main control decoder and load-use
//   hazard detector.
//   Ports:
//     clk    - single clock, register writes on its rising edge
//     reset  - asynchronous, active-high; clears all registers
//     id_if  - id_stage_if slave modport carrying all data/control signals
module id_stage_core (
    input  logic        clk,
    input  logic        reset,
    id_stage_if.slave   id_if
);

    logic [31:0] regs_q [32];
    logic        wr_en_d;
    logic        hazard_d;

    // r0 is never written, so it holds the reset value of zero forever.
    assign wr_en_d = id_if.regWrite && (id_if.writeRegister != 5'd0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'd0;
            end
        end else if (wr_en_d) begin
            regs_q[id_if.writeRegister] <= id_if.writeData;
        end
    end

    // No write-to-read bypass: the write lands on the rising edge, well
    // before the ID stage captures on the falling edge.
    assign id_if.readData1 = regs_q[id_if.readRegister1];
    assign id_if.readData2 = regs_q[id_if.readRegister2];

    // Control fields: WB = {regWrite, memToReg}, MEM = {memRead, memWrite},
    // EX = {regDst, aluOp[1:0], aluSrc}.
    always_comb begin
        id_if.writeBackControl   = 2'b00;
        id_if.memAccessControl   = 2'b00;
        id_if.calculationControl = 4'b0000;
        case (id_if.opCode)
            6'b000000: begin
                id_if.writeBackControl   = 2'b10;
                id_if.calculationControl = 4'b1100;
            end
            6'b100011: begin
                id_if.writeBackControl   = 2'b11;
                id_if.memAccessControl   = 2'b10;
                id_if.calculationControl = 4'b0001;
            end
            6'b101011: begin
                id_if.memAccessControl   = 2'b01;
                id_if.calculationControl = 4'b0001;
            end
            6'b000100: begin
                id_if.calculationControl = 4'b0010;
            end
            6'b001000: begin
                id_if.writeBackControl   = 2'b10;
                id_if.calculationControl = 4'b0001;
            end
            default: ;
        endcase
    end

    // A load targeting r0 still stalls on a match; the stall lifts once the
    // bubble reaches ID/EX and drops idExMemRead.
    assign hazard_d = id_if.idExMemRead &&
                      ((id_if.idExRt == id_if.ifIdRs) || (id_if.idExRt == id_if.ifIdRt));

    assign id_if.pcWrite           = ~hazard_d;
    assign id_if.ifIdWrite         = ~hazard_d;
    assign id_if.bubbleInstruction = hazard_d;

endmodule

// File: tb/tb_id_stage_core.sv
module tb_id_stage_core;

    logic clk = 1'b0;
    logic reset = 1'b0;

    id_stage_if bus ();

    id_stage_core dut (
        .clk   (clk),
        .reset (reset),
        .id_if (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    bit          cmp_en   = 1'b0;
    logic [31:0] model [32];

    // Reference register file: plain array, written by the architectural rule.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) model[i] = 32'd0;
        end else if (bus.regWrite === 1'b1 && bus.writeRegister != 5'd0) begin
            model[bus.writeRegister] = bus.writeData;
        end
    end

    // Expected {WB, MEM, EX} from the opcode table.
    function automatic logic [7:0] exp_ctrl(input logic [5:0] op);
        logic [7:0] r;
        r = 8'b00_00_0000;
        if (op == 6'h00) r = 8'b10_00_1100;
        if (op == 6'h23) r = 8'b11_10_0001;
        if (op == 6'h2B) r = 8'b00_01_0001;
        if (op == 6'h04) r = 8'b00_00_0010;
        if (op == 6'h08) r = 8'b10_00_0001;
        return r;
    endfunction

    function automatic logic [2:0] exp_haz(input logic mr, input logic [4:0] rt,
                                           input logic [4:0] rs, input logic [4:0] rt2);
        logic h;
        h = mr && (rt == rs || rt == rt2);
        return h ? 3'b001 : 3'b110;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("rd1", bus.readData1, model[bus.readRegister1]);
            check("rd2", bus.readData2, model[bus.readRegister2]);
            check("ctrl", {24'd0, bus.writeBackControl, bus.memAccessControl, bus.calculationControl},
                  {24'd0, exp_ctrl(bus.opCode)});
            check("hazard", {29'd0, bus.pcWrite, bus.ifIdWrite, bus.bubbleInstruction},
                  {29'd0, exp_haz(bus.idExMemRead, bus.idExRt, bus.ifIdRs, bus.ifIdRt)});
        end
    end

    task automatic at_neg();
        @(negedge clk);
        #1;
    endtask

    task automatic set_haz(input logic mr, input logic [4:0] rt, input logic [4:0] rs, input logic [4:0] rt2);
        bus.idExMemRead = mr;
        bus.idExRt      = rt;
        bus.ifIdRs      = rs;
        bus.ifIdRt      = rt2;
        #1;
    endtask

    function automatic logic [31:0] haz_out();
        return {29'd0, bus.pcWrite, bus.ifIdWrite, bus.bubbleInstruction};
    endfunction

    logic [5:0] ops  [6];
    logic [7:0] ctls [6];
    int         pick;

    initial begin
        bus.readRegister1 = 5'd0;
        bus.readRegister2 = 5'd0;
        bus.writeRegister = 5'd0;
        bus.writeData     = 32'd0;
        bus.regWrite      = 1'b0;
        bus.opCode        = 6'd0;
        bus.idExMemRead   = 1'b0;
        bus.idExRt        = 5'd0;
        bus.ifIdRs        = 5'd0;
        bus.ifIdRt        = 5'd0;
        #1 reset = 1'b1;

        // Reset then read.
        at_neg();
        bus.readRegister1 = 5'd0;
        bus.readRegister2 = 5'd5;
        #1;
        check("rst_r0", bus.readData1, 32'h0);
        check("rst_r5", bus.readData2, 32'h0);
        bus.readRegister1 = 5'd31;
        #1;
        check("rst_r31", bus.readData1, 32'h0);
        cmp_en = 1'b1;
        reset = 1'b0;
        at_neg();
        check("post_rst_r31", bus.readData1, 32'h0);

        // Write then read, read-during-write returns the old value first.
        bus.writeRegister = 5'd7;
        bus.writeData     = 32'hDEADBEEF;
        bus.regWrite      = 1'b1;
        bus.readRegister1 = 5'd7;
        #1;
        check("r7_before_edge", bus.readData1, 32'h0);
        at_neg();
        check("r7_written", bus.readData1, 32'hDEADBEEF);
        bus.writeRegister = 5'd0;
        bus.writeData     = 32'h12345678;
        bus.readRegister1 = 5'd0;
        at_neg();
        check("r0_ignored", bus.readData1, 32'h0);
        bus.regWrite      = 1'b0;
        bus.writeRegister = 5'd7;
        bus.writeData     = 32'hFFFFFFFF;
        bus.readRegister2 = 5'd7;
        at_neg();
        check("r7_no_we", bus.readData2, 32'hDEADBEEF);

        // Decoder sweep.
        ops[0] = 6'h00; ctls[0] = 8'b10_00_1100;
        ops[1] = 6'h23; ctls[1] = 8'b11_10_0001;
        ops[2] = 6'h2B; ctls[2] = 8'b00_01_0001;
        ops[3] = 6'h04; ctls[3] = 8'b00_00_0010;
        ops[4] = 6'h08; ctls[4] = 8'b10_00_0001;
        ops[5] = 6'h3F; ctls[5] = 8'b00_00_0000;
        for (int i = 0; i < 6; i++) begin
            bus.opCode = ops[i];
            #1;
            check("decode", {24'd0, bus.writeBackControl, bus.memAccessControl, bus.calculationControl},
                  {24'd0, ctls[i]});
        end

        // Load-use hazard cases.
        set_haz(1'b1, 5'd3, 5'd3, 5'd9);
        check("haz_rs", haz_out(), 32'b001);
        set_haz(1'b1, 5'd3, 5'd4, 5'd9);
        check("haz_none", haz_out(), 32'b110);
        set_haz(1'b1, 5'd3, 5'd4, 5'd3);
        check("haz_rt", haz_out(), 32'b001);
        set_haz(1'b0, 5'd3, 5'd3, 5'd9);
        check("haz_no_load", haz_out(), 32'b110);
        set_haz(1'b1, 5'd0, 5'd0, 5'd9);
        check("haz_r0", haz_out(), 32'b001);
        at_neg();
        // Stall persists while the condition holds.
        check("haz_persist", haz_out(), 32'b001);

        // Reset mid-operation.
        bus.regWrite = 1'b1;
        for (int i = 1; i < 32; i++) begin
            bus.writeRegister = i[4:0];
            bus.writeData     = i;
            at_neg();
        end
        bus.regWrite      = 1'b0;
        bus.readRegister1 = 5'd31;
        bus.readRegister2 = 5'd1;
        #1;
        check("fill_r31", bus.readData1, 32'd31);
        check("fill_r1", bus.readData2, 32'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_r31", bus.readData1, 32'h0);
        check("mid_rst_r1", bus.readData2, 32'h0);
        bus.writeRegister = 5'd9;
        bus.writeData     = 32'hAAAA5555;
        bus.regWrite      = 1'b1;
        bus.readRegister1 = 5'd9;
        at_neg();
        check("rst_blocks_wr", bus.readData1, 32'h0);
        reset = 1'b0;
        bus.regWrite = 1'b0;
        at_neg();
        check("rst_wr_dropped", bus.readData1, 32'h0);

        // Randomized traffic checked every cycle by the compare process.
        for (int c = 0; c < 500; c++) begin
            bus.readRegister1 = 5'($urandom_range(0, 31));
            bus.readRegister2 = 5'($urandom_range(0, 31));
            bus.writeRegister = 5'($urandom_range(0, 31));
            bus.writeData     = $urandom;
            bus.regWrite      = 1'($urandom_range(0, 1));
            pick = $urandom_range(0, 6);
            if (pick < 6) bus.opCode = ops[pick];
            else          bus.opCode = 6'($urandom_range(0, 63));
            bus.idExMemRead = 1'($urandom_range(0, 1));
            bus.idExRt      = 5'($urandom_range(0, 3));
            bus.ifIdRs      = 5'($urandom_range(0, 3));
            bus.ifIdRt      = 5'($urandom_range(0, 3));
            reset           = ($urandom_range(0, 49) == 0);
            at_neg();
        end
        reset = 1'b0;
        at_neg();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
